// File: rtl/response_unit.sv
// Reply-frame transmitter: sends ACK/NAK/memory-dump frames to the UART over valid/ready.
// Optional macro RESPONSE_CHECKSUM_EN appends an XOR checksum byte to every frame.
module response_unit #(
  parameter int unsigned IAGC_STATUS_SIZE = 4,
  parameter int unsigned CMD_PARAM_SIZE   = 4,
  parameter int unsigned DATA_SIZE        = 8,
  parameter int unsigned MEM_ADDR_SIZE    = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic [CMD_PARAM_SIZE-1:0]   i_cmd_op,
  input  logic [CMD_PARAM_SIZE-1:0]   i_cmd_param,
  input  logic                        i_rsp_start,
  output logic                        o_mem_rd_en,
  output logic [MEM_ADDR_SIZE-1:0]    o_mem_addr,
  input  logic [DATA_SIZE-1:0]        i_mem_data,
  output logic [DATA_SIZE-1:0]        o_tx_data,
  output logic                        o_tx_valid,
  input  logic                        i_tx_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam logic [IAGC_STATUS_SIZE-1:0] ST_CMD_ERROR = IAGC_STATUS_SIZE'(4'b0110);
  localparam logic [IAGC_STATUS_SIZE-1:0] ST_DUMP_MEM  = IAGC_STATUS_SIZE'(4'b0111);
  localparam logic [DATA_SIZE-1:0]        BYTE_ACK     = DATA_SIZE'(8'h06);
  localparam logic [DATA_SIZE-1:0]        BYTE_NAK     = DATA_SIZE'(8'h15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ECHO,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_DATA,
    S_DONE
`ifdef RESPONSE_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                      state_q, state_d;
  logic [CMD_PARAM_SIZE-1:0]   op_q, op_d;
  logic [CMD_PARAM_SIZE-1:0]   param_q, param_d;
  logic [IAGC_STATUS_SIZE-1:0] status_q, status_d;
  logic [MEM_ADDR_SIZE-1:0]    addr_q, addr_d;
  logic [DATA_SIZE-1:0]        tx_data_q, tx_data_d;
  logic                        tx_valid_q, tx_valid_d;
  logic                        rd_en_q, rd_en_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        xfer;
  logic                        frame_end;
`ifdef RESPONSE_CHECKSUM_EN
  logic [DATA_SIZE-1:0]        csum_q, csum_d;
`endif

  assign xfer = tx_valid_q && i_tx_ready;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    param_d    = param_q;
    status_d   = status_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    frame_end  = 1'b0;
`ifdef RESPONSE_CHECKSUM_EN
    csum_d     = xfer ? (csum_q ^ tx_data_q) : csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_rsp_start) begin
          op_d       = i_cmd_op;
          param_d    = i_cmd_param;
          status_d   = i_iagc_status;
          addr_d     = '0;
          tx_data_d  = (i_iagc_status == ST_CMD_ERROR) ? BYTE_NAK : BYTE_ACK;
          tx_valid_d = 1'b1;
          state_d    = S_HDR;
`ifdef RESPONSE_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          tx_data_d = DATA_SIZE'({op_q, param_q});
          state_d   = S_ECHO;
        end
      end
      S_ECHO: begin
        if (xfer) begin
          if (status_q == ST_DUMP_MEM) begin
            tx_valid_d = 1'b0;
            rd_en_d    = 1'b1;
            state_d    = S_MEM_REQ;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_MEM_REQ: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        tx_data_d  = i_mem_data;
        tx_valid_d = 1'b1;
        state_d    = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          if (addr_q == MEM_ADDR_SIZE'(param_q)) begin
            frame_end = 1'b1;
          end else begin
            addr_d     = addr_q + MEM_ADDR_SIZE'(1);
            tx_valid_d = 1'b0;
            rd_en_d    = 1'b1;
            state_d    = S_MEM_REQ;
          end
        end
      end
`ifdef RESPONSE_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Last payload byte accepted: either append the checksum or close the frame
    if (frame_end) begin
`ifdef RESPONSE_CHECKSUM_EN
      tx_data_d  = csum_q ^ tx_data_q;
      tx_valid_d = 1'b1;
      state_d    = S_CSUM;
`else
      tx_valid_d = 1'b0;
      done_d     = 1'b1;
      state_d    = S_DONE;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      param_q    <= '0;
      status_q   <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESPONSE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      param_q    <= param_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RESPONSE_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign o_mem_rd_en = rd_en_q;
  assign o_mem_addr  = addr_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_response_unit.sv
// Scoreboard bench for response_unit: stimulus pushes expected bytes/done markers, a monitor pops and checks.
module tb_response_unit;

  typedef struct packed {
    logic       is_done;
    logic [7:0] b;
  } exp_t;

  logic       clk;
  logic       i_reset;
  logic [3:0] i_iagc_status;
  logic [3:0] i_cmd_op;
  logic [3:0] i_cmd_param;
  logic       i_rsp_start;
  logic       o_mem_rd_en;
  logic [3:0] o_mem_addr;
  logic [7:0] i_mem_data;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_done;

  int   checks   = 0;
  int   failures = 0;
  int   ready_mode = 1;   // 0 = low, 1 = high, 2 = random 30% high
  exp_t       exp_q[$];
  logic [3:0] addr_q[$];
  logic [7:0] mem[16];

  response_unit dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_iagc_status(i_iagc_status),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_param  (i_cmd_param),
    .i_rsp_start  (i_rsp_start),
    .o_mem_rd_en  (o_mem_rd_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample memory with one-cycle read latency
  always @(posedge clk) begin
    if (o_mem_rd_en) i_mem_data <= mem[o_mem_addr];
  end

  // Transmitter ready driver
  initial begin
    i_tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       i_tx_ready = 1'b0;
        1:       i_tx_ready = 1'b1;
        default: i_tx_ready = ($urandom_range(0, 9) < 3);
      endcase
    end
  end

  // Monitor: byte/done ordering, hold stability, memory strobes
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_rd;
    exp_t       e;
    logic [3:0] ea;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_rd    = 1'b0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!o_tx_valid || o_tx_data != prev_data) begin
            failures++;
            $display("FAIL hold: valid=%0b data=%02h required valid=1 data=%02h", o_tx_valid, o_tx_data, prev_data);
          end
        end
        if (o_tx_valid && i_tx_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_byte: got %02h, required nothing (queue empty)", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            if (e.is_done || e.b != o_tx_data) begin
              failures++;
              $display("FAIL tx_byte: got %02h, required %s %02h", o_tx_data, e.is_done ? "done" : "byte", e.b);
            end
          end
        end
        if (o_done) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL done: got done pulse, required nothing (queue empty)");
          end else begin
            e = exp_q.pop_front();
            if (!e.is_done) begin
              failures++;
              $display("FAIL done: got done pulse, required byte %02h", e.b);
            end
          end
        end
        if (o_mem_rd_en) begin
          checks++;
          if (prev_rd) begin
            failures++;
            $display("FAIL rd_strobe: got 2-cycle strobe, required 1-cycle");
          end else if (addr_q.size() == 0) begin
            failures++;
            $display("FAIL mem_addr: got read at %0d, required no read", o_mem_addr);
          end else begin
            ea = addr_q.pop_front();
            if (ea != o_mem_addr) begin
              failures++;
              $display("FAIL mem_addr: got %0d, required %0d", o_mem_addr, ea);
            end
          end
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
        prev_rd    = o_mem_rd_en;
      end
    end
  end

  task automatic push_exp(input logic [3:0] st, input logic [3:0] op, input logic [3:0] prm);
    exp_t e;
    logic [7:0] hdr;
    hdr = (st == 4'b0110) ? 8'h15 : 8'h06;
    e.is_done = 1'b0;
    e.b = hdr;        exp_q.push_back(e);
    e.b = {op, prm};  exp_q.push_back(e);
    if (st == 4'b0111) begin
      for (int i = 0; i <= int'(prm); i++) begin
        e.b = mem[i];
        exp_q.push_back(e);
        addr_q.push_back(4'(i));
      end
    end
`ifdef RESPONSE_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = hdr ^ {op, prm};
      if (st == 4'b0111) begin
        for (int i = 0; i <= int'(prm); i++) x = x ^ mem[i];
      end
      e.b = x;
      exp_q.push_back(e);
    end
`endif
    e.is_done = 1'b1;
    e.b = 8'h00;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 while the DUT is idle
  task automatic start_frame(input logic [3:0] st, input logic [3:0] op, input logic [3:0] prm);
    push_exp(st, op, prm);
    i_iagc_status = st;
    i_cmd_op      = op;
    i_cmd_param   = prm;
    i_rsp_start   = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_start = 1'b0;
    checks++;
    if (!o_tx_valid || !o_busy) begin
      failures++;
      $display("FAIL first_byte_latency: valid=%0b busy=%0b required 1 1", o_tx_valid, o_busy);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((o_busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d required idle with 0 pending", name, o_busy, exp_q.size());
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (o_tx_valid || o_busy || o_mem_rd_en || o_done) begin
      failures++;
      $display("FAIL %s: valid=%0b busy=%0b rd_en=%0b done=%0b required all 0",
               name, o_tx_valid, o_busy, o_mem_rd_en, o_done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_reset       = 1'b1;
    i_iagc_status = '0;
    i_cmd_op      = '0;
    i_cmd_param   = '0;
    i_rsp_start   = 1'b0;
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    for (int i = 3; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_state");
    checks++;
    if (o_tx_data != 8'h00 || o_mem_addr != 4'h0) begin
      failures++;
      $display("FAIL reset_data: tx_data=%02h addr=%0d required 00 0", o_tx_data, o_mem_addr);
    end
    i_reset = 1'b0;
    @(posedge clk);
    #1;

    // ACK
    ready_mode = 1;
    start_frame(4'b0010, 4'h3, 4'hA);
    wait_idle("ack");

    // NAK
    start_frame(4'b0110, 4'hF, 4'h0);
    wait_idle("nak");

    // DUMP, status changes mid-frame must not matter
    start_frame(4'b0111, 4'h7, 4'h2);
    i_iagc_status = 4'b0110;
    wait_idle("dump");

    // DUMP of all 16 words under random backpressure
    ready_mode = 2;
    start_frame(4'b0111, 4'h9, 4'hF);
    i_iagc_status = 4'b0010;
    wait_idle("backpressure");

    // Start while busy is ignored; start right after done begins a new frame
    ready_mode = 0;
    start_frame(4'b0010, 4'h5, 4'h9);
    ready_mode = 1;
    @(posedge clk);
    #1;
    ready_mode = 0;
    i_iagc_status = 4'b0111;
    i_cmd_op      = 4'hC;
    i_cmd_param   = 4'hC;
    i_rsp_start   = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 1;
    begin
      int n;
      n = 0;
      while (!o_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!o_done) begin
        failures++;
        $display("FAIL busy_start_done: done=%0b required 1 within 100 cycles", o_done);
      end
    end
    @(posedge clk);
    #1;
    start_frame(4'b0000, 4'h1, 4'h2);
    wait_idle("back_to_back");

    // Reset in the middle of a stalled DUMP
    ready_mode = 0;
    start_frame(4'b0111, 4'h4, 4'h5);
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("reset_mid_frame_1");
    @(posedge clk);
    #1;
    check_quiet("reset_mid_frame_2");
    i_reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("after_reset_idle");

    // Recovery frame after reset
    start_frame(4'b0111, 4'h7, 4'h2);
    wait_idle("post_reset_dump");

    checks++;
    if (addr_q.size() != 0) begin
      failures++;
      $display("FAIL mem_reads: got %0d reads missing, required 0", addr_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
